// File: rtl/cnn_acc_pkg.sv
// cnn_acc_pkg: shared FSM state type and accumulator width helper for signed_accumulator
package cnn_acc_pkg;
  typedef enum logic {IDLE, ACCUM} state_t;
  function automatic int acc_width(input int data_w, input int num_add_w, input int pass_w);
    return data_w + num_add_w + pass_w;
  endfunction
endpackage

// File: rtl/lane_sum.sv
// lane_sum: masks lanes at or above num_kernel_i, sign-extends the rest and sums them
//   data_i       packed lanes, lane i at [DATA_WIDTH*i +: DATA_WIDTH]
//   num_kernel_i active lane count (values above MAX_NUM_ADD enable every lane)
//   sum_o        signed lane sum, ACC_WIDTH bits
module lane_sum #(
  parameter int MAX_NUM_ADD = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ADD_WIDTH = 3,
  parameter int ACC_WIDTH = 19
) (
  input  logic [MAX_NUM_ADD*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_ADD_WIDTH-1:0]          num_kernel_i,
  output logic signed [ACC_WIDTH-1:0]       sum_o
);
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < MAX_NUM_ADD; i++)
      sum_o = sum_o + ((i < int'(num_kernel_i)) ? ACC_WIDTH'($signed(data_i[DATA_WIDTH*i +: DATA_WIDTH])) : '0);
  end
endmodule

// File: rtl/signed_accumulator.sv
// signed_accumulator: two-stage signed multi-lane accumulator emitting one result per cfg_num_pass beats
//   clk, reset                 clock, synchronous active-high reset
//   cfg_num_kernel/num_pass    lane count and beats per result, latched on a group's first beat
//   ibus_valid/ready/read_data input beats (valid/ready handshake)
//   obus_valid/ready/write_data results (valid/ready handshake)
//   busy                       FSM in ACCUM or a beat is in flight
//   Define SIGNED_ACCUMULATOR_SAT_EN to saturate the result instead of wrapping it.
module signed_accumulator
  import cnn_acc_pkg::*;
#(
  parameter int MAX_NUM_ADD = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH = 16,
  parameter int PASS_WIDTH = 8,
  parameter int NUM_ADD_WIDTH = $clog2(MAX_NUM_ADD) + 1,
  parameter int IBUS_WIDTH = MAX_NUM_ADD * DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_ADD_WIDTH-1:0] cfg_num_kernel,
  input  logic [PASS_WIDTH-1:0]    cfg_num_pass,
  input  logic                     ibus_valid,
  output logic                     ibus_ready,
  input  logic [IBUS_WIDTH-1:0]    ibus_read_data,
  output logic                     obus_valid,
  input  logic                     obus_ready,
  output logic [OUT_WIDTH-1:0]     obus_write_data,
  output logic                     busy
);
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, NUM_ADD_WIDTH, PASS_WIDTH);
  state_t state_q, state_d;
  logic [PASS_WIDTH-1:0] beat_cnt_q, beat_cnt_d, np_q, np_d, np_in, cur_np;
  logic [NUM_ADD_WIDTH-1:0] nk_q, nk_d, cur_nk;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, out_valid_q, out_valid_d;
  logic signed [ACC_WIDTH-1:0] s1_sum_q, s1_sum_d, acc_q, acc_d, acc_sum, lane_sum_w;
  logic [OUT_WIDTH-1:0] out_q, out_d, result;
  logic stall, accept, first, last, s2_last;

  assign stall = out_valid_q & ~obus_ready;
  assign accept = ibus_valid & ~stall;
  assign first = state_q == IDLE;
  assign np_in = (cfg_num_pass == '0) ? PASS_WIDTH'(1) : cfg_num_pass;
  // The first beat of a group uses live config; later beats use the latched copy.
  assign cur_np = first ? np_in : np_q;
  assign cur_nk = first ? cfg_num_kernel : nk_q;
  assign last = beat_cnt_q == cur_np - PASS_WIDTH'(1);
  assign acc_sum = acc_q + s1_sum_q;
  assign s2_last = ~stall & s1_valid_q & s1_last_q;

  lane_sum #(
    .MAX_NUM_ADD(MAX_NUM_ADD),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_ADD_WIDTH(NUM_ADD_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_lane_sum (
    .data_i(ibus_read_data),
    .num_kernel_i(cur_nk),
    .sum_o(lane_sum_w)
  );

`ifdef SIGNED_ACCUMULATOR_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] HI = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] LO = ~HI;
  assign result = (acc_sum > HI) ? OUT_WIDTH'(HI) : (acc_sum < LO) ? OUT_WIDTH'(LO) : OUT_WIDTH'(acc_sum);
`else
  assign result = OUT_WIDTH'(acc_sum);
`endif

  always_comb begin
    state_d = accept ? (last ? IDLE : ACCUM) : state_q;
    beat_cnt_d = accept ? (last ? '0 : beat_cnt_q + PASS_WIDTH'(1)) : beat_cnt_q;
    nk_d = (accept & first) ? cfg_num_kernel : nk_q;
    np_d = (accept & first) ? np_in : np_q;
    s1_valid_d = stall ? s1_valid_q : accept;
    s1_sum_d = stall ? s1_sum_q : lane_sum_w;
    s1_last_d = stall ? s1_last_q : last;
    acc_d = (~stall & s1_valid_q) ? (s1_last_q ? '0 : acc_sum) : acc_q;
    out_d = s2_last ? result : out_q;
    // A consumed result is replaced in the same cycle when a new one completes.
    out_valid_d = s2_last | stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_cnt_q <= '0;
      nk_q <= '0;
      np_q <= '0;
      s1_valid_q <= 1'b0;
      s1_sum_q <= '0;
      s1_last_q <= 1'b0;
      acc_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_cnt_q <= beat_cnt_d;
      nk_q <= nk_d;
      np_q <= np_d;
      s1_valid_q <= s1_valid_d;
      s1_sum_q <= s1_sum_d;
      s1_last_q <= s1_last_d;
      acc_q <= acc_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ibus_ready = ~stall;
  assign obus_valid = out_valid_q;
  assign obus_write_data = out_q;
  assign busy = (state_q == ACCUM) | s1_valid_q;
endmodule
